// File: rtl/pwm_avmm_slave.sv
// rtl/pwm_avmm_slave.sv - Avalon-MM multi-channel PWM generator with shadowed period/duty and wrap interrupt.
module pwm_avmm_slave #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [CH_NUM-1:0] pwm_out,
    output logic              irq
);

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PERIOD = 4'd1;
    localparam logic [3:0] ADDR_PRESC  = 4'd2;
    localparam logic [3:0] ADDR_IRQ    = 4'd3;
    localparam logic [3:0] ADDR_DUTY0  = 4'd4;
    localparam logic [3:0] ADDR_CNT    = 4'd12;

    localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(255);

    logic              ctrl_en;
    logic [CH_NUM-1:0] ch_en;
    logic [CNT_W-1:0]  period_sh;
    logic [15:0]       presc;
    logic              wrap_pend;
    logic              irq_en;
    logic [CNT_W-1:0]  duty_sh [CH_NUM];

    logic [CNT_W-1:0]  period_act;
    logic [CNT_W-1:0]  duty_act [CH_NUM];
    logic [15:0]       presc_cnt;
    logic [CNT_W-1:0]  cnt;

    logic              tick;
    logic              wrap;
    logic              wr_irq;
    logic              wrap_pend_nxt;
    logic              irq_en_nxt;
    logic [CH_NUM-1:0] pwm_nxt;
    logic [31:0]       ctrl_word;
    logic [31:0]       rd_mux;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    assign ctrl_word = {{(24-CH_NUM){1'b0}}, ch_en, 7'd0, ctrl_en};
    assign wr_irq    = avs_write && (avs_address == ADDR_IRQ);

    always_comb begin
        tick = ctrl_en && (presc_cnt == presc);
        wrap = tick && (cnt == period_act);
        // A wrap in the same cycle as a W1C keeps the pending bit set.
        wrap_pend_nxt = wrap_pend;
        if (wr_irq && avs_byteenable[0] && avs_writedata[0]) begin
            wrap_pend_nxt = 1'b0;
        end
        if (wrap) begin
            wrap_pend_nxt = 1'b1;
        end
        irq_en_nxt = (wr_irq && avs_byteenable[2]) ? avs_writedata[16] : irq_en;
        pwm_nxt = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            pwm_nxt[n] = ctrl_en && ch_en[n] && (cnt < duty_act[n]);
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (avs_address)
            ADDR_CTRL:   rd_mux = ctrl_word;
            ADDR_PERIOD: rd_mux = 32'(period_sh);
            ADDR_PRESC:  rd_mux = {16'd0, presc};
            ADDR_IRQ:    rd_mux = {15'd0, irq_en, 15'd0, wrap_pend};
            ADDR_CNT:    rd_mux = 32'(cnt);
            default:     rd_mux = 32'd0;
        endcase
        for (int n = 0; n < CH_NUM; n++) begin
            if (avs_address == 4'(ADDR_DUTY0 + n)) begin
                rd_mux = 32'(duty_sh[n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en           <= 1'b0;
            ch_en             <= '0;
            period_sh         <= PERIOD_RST;
            presc             <= '0;
            wrap_pend         <= 1'b0;
            irq_en            <= 1'b0;
            irq               <= 1'b0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= 32'd0;
            for (int n = 0; n < CH_NUM; n++) begin
                duty_sh[n] <= '0;
            end
        end else begin
            if (avs_write && (avs_address == ADDR_CTRL)) begin
                ctrl_en <= 1'(be_merge(ctrl_word, avs_writedata, avs_byteenable));
                ch_en   <= CH_NUM'(be_merge(ctrl_word, avs_writedata, avs_byteenable) >> 8);
            end
            if (avs_write && (avs_address == ADDR_PERIOD)) begin
                period_sh <= CNT_W'(be_merge(32'(period_sh), avs_writedata, avs_byteenable));
            end
            if (avs_write && (avs_address == ADDR_PRESC)) begin
                presc <= 16'(be_merge({16'd0, presc}, avs_writedata, avs_byteenable));
            end
            for (int n = 0; n < CH_NUM; n++) begin
                if (avs_write && (avs_address == 4'(ADDR_DUTY0 + n))) begin
                    duty_sh[n] <= CNT_W'(be_merge(32'(duty_sh[n]), avs_writedata, avs_byteenable));
                end
            end
            wrap_pend         <= wrap_pend_nxt;
            irq_en            <= irq_en_nxt;
            irq               <= wrap_pend_nxt & irq_en_nxt;
            avs_readdatavalid <= avs_read;
            avs_readdata      <= avs_read ? rd_mux : 32'd0;
        end
    end

    // Active period/duty follow the shadows while disabled and reload only at wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt  <= '0;
            cnt        <= '0;
            period_act <= PERIOD_RST;
            pwm_out    <= '0;
            for (int n = 0; n < CH_NUM; n++) begin
                duty_act[n] <= '0;
            end
        end else begin
            pwm_out <= pwm_nxt;
            if (!ctrl_en) begin
                presc_cnt  <= '0;
                cnt        <= '0;
                period_act <= period_sh;
                duty_act   <= duty_sh;
            end else begin
                presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
                if (tick) begin
                    cnt <= wrap ? '0 : cnt + CNT_W'(1);
                end
                if (wrap) begin
                    period_act <= period_sh;
                    duty_act   <= duty_sh;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_avmm_slave.sv
// tb/tb_pwm_avmm_slave.sv - Scoreboard bench for pwm_avmm_slave: read responses checked by a monitor, PWM/irq by directed vectors.
module tb_pwm_avmm_slave;

    localparam logic [3:0] A_CTRL = 4'd0, A_PERIOD = 4'd1, A_PRESC = 4'd2, A_IRQ = 4'd3;
    localparam logic [3:0] A_DUTY0 = 4'd4, A_DUTY1 = 4'd5, A_CNT = 4'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [3:0]  pwm_out;
    logic        irq;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    rd_exp_t sb[$];
    rd_exp_t mon_e;
    int cyc = 0;
    int wr_cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    pwm_avmm_slave dut (
        .clk               (clk),
        .rst               (rst),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .pwm_out           (pwm_out),
        .irq               (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (avs_readdatavalid) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: readdatavalid at cycle %0d with nothing outstanding", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (avs_readdata !== mon_e.data || cyc != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL rd_addr%0d: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                             mon_e.addr, avs_readdata, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end else if (avs_readdata !== 32'd0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_idle_data: got 0x%0h, expected 0x0 at cycle %0d", avs_readdata, cyc);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        rd_exp_t e;
        e.addr = int'(a);
        e.data = exp;
        e.cyc  = cyc + 1;
        sb.push_back(e);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk); #1;
        avs_read    = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_cyc         = cyc;
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        @(posedge clk); #1;
        avs_write      = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic neg_at(input int t);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc < t && g < 2000);
        if (cyc != t) begin
            n_tests++;
            n_fail++;
            $display("FAIL neg_at: reached cycle %0d, expected %0d", cyc, t);
        end
    endtask

    // Expected pwm after an enable write at wr_cyc: counter = ((i-1)/(p+1)) % plen one cycle earlier.
    task automatic run_check(input int ch, input int ncyc, input int p, input int plen,
                             input int duty, input string nm);
        int base = wr_cyc;
        int i;
        logic exp;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            i = cyc - base - 1;
            exp = (i >= 1) && ((((i - 1) / (p + 1)) % plen) < duty);
            check(nm, 32'(pwm_out[ch]), 32'(exp));
        end
    endtask

    initial begin
        int w;
        int rel;
        logic exp;
        rst = 1'b1;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_pwm", 32'(pwm_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rdv", 32'(avs_readdatavalid), 32'h0);
        rd(A_CTRL, 32'h0);
        rd(A_PERIOD, 32'hFF);
        rd(A_PRESC, 32'h0);
        rd(A_IRQ, 32'h0);
        rd(A_DUTY0, 32'h0);
        rd(A_CNT, 32'h0);
        wr(4'd13, 32'hFFFF_FFFF, 4'hF);
        rd(4'd13, 32'h0);

        wr(A_PERIOD, 32'd9, 4'hF);
        wr(A_DUTY0, 32'd3, 4'hF);
        wr(A_CTRL, 32'h101, 4'hF);
        run_check(0, 30, 0, 10, 3, "pwm0_d3");
        step();
        rd(A_IRQ, 32'h1);
        wr(A_IRQ, 32'h1, 4'h1);
        rd(A_IRQ, 32'h0);
        check("irq_disabled", 32'(irq), 32'h0);

        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_DUTY0, 32'd3, 4'hF);
        wr(A_CTRL, 32'h101, 4'hF);
        w = wr_cyc;
        step();
        wr(A_DUTY0, 32'd7, 4'hF);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            rel = cyc - w;
            exp = (((rel - 2) % 10) < ((rel >= 12) ? 7 : 3));
            check("pwm0_duty_update", 32'(pwm_out[0]), 32'(exp));
        end
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_DUTY0, 32'd0, 4'hF);
        wr(A_CTRL, 32'h101, 4'hF);
        run_check(0, 25, 0, 10, 0, "pwm0_d0");
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_DUTY0, 32'd12, 4'hF);
        wr(A_CTRL, 32'h101, 4'hF);
        run_check(0, 25, 0, 10, 12, "pwm0_d12");

        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_PRESC, 32'd3, 4'hF);
        wr(A_PERIOD, 32'd1, 4'hF);
        wr(A_DUTY1, 32'd1, 4'hF);
        wr(A_CTRL, 32'h201, 4'hF);
        w = wr_cyc;
        run_check(1, 24, 3, 2, 1, "pwm1_presc3");
        check("pwm0_masked", 32'(pwm_out[0]), 32'h0);
        for (int k = 0; k < 8; k++) begin
            rd(A_CNT, 32'(((cyc - w - 1) / 4) % 2));
        end
        rd(A_CTRL, 32'h201);
        rd(A_PRESC, 32'h3);

        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_PRESC, 32'd0, 4'hF);
        wr(A_PERIOD, 32'd9, 4'hF);
        wr(A_IRQ, 32'h0001_0001, 4'hF);
        wr(A_CTRL, 32'h101, 4'hF);
        w = wr_cyc;
        neg_at(w + 10);
        check("irq_before_wrap", 32'(irq), 32'h0);
        neg_at(w + 11);
        check("irq_after_wrap", 32'(irq), 32'h1);
        goto_cyc(w + 20);
        wr(A_IRQ, 32'h0001_0001, 4'hF);
        neg_at(w + 21);
        check("irq_w1c_on_wrap", 32'(irq), 32'h1);
        rd(A_IRQ, 32'h0001_0001);
        avs_address    = A_IRQ;
        avs_writedata  = 32'h1;
        avs_byteenable = 4'h1;
        avs_write      = 1'b1;
        @(negedge clk);
        check("irq_w1c_same_cycle", 32'(irq), 32'h1);
        @(posedge clk); #1;
        avs_write = 1'b0;
        @(negedge clk);
        check("irq_w1c_next_cycle", 32'(irq), 32'h0);
        rd(A_IRQ, 32'h0001_0000);

        neg_at(w + 31);
        check("irq_before_rst", 32'(irq), 32'h1);
        check("pwm0_before_rst", 32'(pwm_out[0]), 32'h1);
        rst = 1'b1;
        avs_address = A_PERIOD;
        avs_read = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        avs_read = 1'b0;
        @(negedge clk);
        check("mid_rst_pwm", 32'(pwm_out), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_rdv", 32'(avs_readdatavalid), 32'h0);
        rd(A_CTRL, 32'h0);
        rd(A_PERIOD, 32'hFF);
        rd(A_PRESC, 32'h0);
        rd(A_IRQ, 32'h0);
        rd(A_DUTY0, 32'h0);
        rd(A_DUTY1, 32'h0);
        rd(A_CNT, 32'h0);

        wr(A_PERIOD, 32'hFFFF_FFFF, 4'h1);
        rd(A_PERIOD, 32'h00FF);
        wr(A_PERIOD, 32'h1234_5678, 4'h2);
        rd(A_PERIOD, 32'h56FF);
        wr(A_PERIOD, 32'hFFFF_FFFF, 4'hF);
        rd(A_PERIOD, 32'hFFFF);
        wr(A_PRESC, 32'hABCD_1234, 4'hF);
        rd(A_PRESC, 32'h1234);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_missing: %0d read responses never arrived", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_avmm_slave.md
Name: pwm_avmm_slave

Overview:
- Avalon-MM slave on the HPS lightweight H2F bridge of slon1_soc; a multi-channel PWM generator owned by the FPGA fabric, downstream of the SoC.
- HPS software programs period, prescaler and per-channel duty, and receives an interrupt at every PWM period wrap.
- Shadow registers make period/duty updates glitch-free: new values take effect only at the period boundary.

Parameters:
- CH_NUM, 4, number of PWM channels (1..8).
- CNT_W, 16, width of the period counter and of the duty/period fields (2..32).

Ports:
- clk  input  1  system clock; the same clock as clk_clk of slon1_soc.
- rst  input  1  synchronous, active-high reset.
- avs_address  input  4  word address.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_byteenable  input  4  byte lanes for writes.
- avs_readdata  output  32  read data, valid with avs_readdatavalid.
- avs_readdatavalid  output  1  read response, fixed latency 1.
- pwm_out  output  CH_NUM  registered PWM outputs.
- irq  output  1  level interrupt to HPS f2h_irq.

Behaviour:
- Bus interface:
  - No waitrequest; fixed read latency 1.
  - avs_readdatavalid is high exactly one cycle after each cycle with avs_read=1. avs_readdata is valid in that same cycle and is 0 otherwise.
  - Unmapped addresses read 0; writes to them are ignored.
  - avs_byteenable is honoured per byte on every register.
  - Field bits above CNT_W are ignored on write and read as 0.
- Register map (word address):
  - 0 CTRL: bit0 EN (global enable); bits[8+CH_NUM-1:8] CH_EN mask. Reset 0.
  - 1 PERIOD: shadow value of the counter top (the period is PERIOD+1 ticks). Reset 0xFF.
  - 2 PRESC: [15:0] prescaler divide-1; tick every PRESC+1 clk cycles. Reset 0.
  - 3 IRQ: bit0 WRAP_PEND (read; write 1 to clear); bit16 IRQ_EN. Reset 0.
  - 4..4+CH_NUM-1 DUTY[n]: shadow duty value. Reset 0.
  - 12 CNT: read-only current counter value.
- Timebase:
  - When EN=1, the prescaler counts 0..PRESC and asserts tick in the cycle where it equals PRESC, then returns to 0.
  - On tick, the counter increments. When tick occurs with counter == period_act, the counter goes to 0, the wrap event fires, and period_act and duty_act[] load from their shadows in that same cycle.
  - Counter and prescaler are free-running wrap-around values; there is no other overflow case.
- Disabled (EN=0):
  - Prescaler and counter are held at 0.
  - pwm_out is 0.
  - Active registers track the shadows every cycle, so the first period after enable uses the current values.
- Enable and write timing:
  - EN 0->1: the counter starts at 0. The first tick occurs PRESC+1 cycles after the write cycle.
  - Shadow writes while EN=1 never change the active period/duty before the next wrap.
  - A shadow write in the same cycle as a wrap is not loaded at that wrap; it is loaded at the following wrap.
- Output:
  - pwm_out[n] is registered and equals EN & CH_EN[n] & (counter < duty_act[n]), with one cycle of latency from the counter.
  - duty_act=0 gives a constant 0 output.
  - duty_act > period_act gives a constant 1 output.
  - Clearing CH_EN[n] forces pwm_out[n] to 0 on the next cycle without disturbing the counter.
- Interrupt:
  - A wrap event sets WRAP_PEND.
  - If a W1C of WRAP_PEND and a wrap happen in the same cycle, the set wins.
  - irq = WRAP_PEND & IRQ_EN. It is registered: it goes high the cycle after WRAP_PEND sets and falls the cycle after the clear.
- Reset:
  - rst high in any cycle, including mid-period or during a pending read, returns all registers to their reset values.
  - pwm_out=0, irq=0, avs_readdatavalid=0 and avs_readdata=0 in the cycle after rst is sampled.
  - A read issued in the cycle rst is sampled gets no response.

Test Plan:
1. Reset, then read addresses 0,1,2,3,4,12 -> readdata 0, 0xFF, 0, 0, 0, 0, each with readdatavalid exactly one cycle after avs_read.
2. PRESC=0, PERIOD=9, DUTY0=3, CTRL=0x101 -> pwm_out[0] is high for 3 cycles then low for 7, repeating every 10 cycles. WRAP_PEND sets every 10 cycles.
3. Running per scenario 2, write DUTY0=7 mid-period -> the current period keeps 3 high cycles; the next period shows 7 high. Also check DUTY0=0 gives always 0 and DUTY0=12 gives always 1.
4. PRESC=3, PERIOD=1, DUTY1=1, CH_EN=0x2, EN=1 -> pwm_out[1] high 4 cycles, low 4 cycles. CNT reads step by one every 4 cycles.
5. IRQ_EN=1 -> irq rises the cycle after a wrap. A W1C written in the cycle of the next wrap leaves WRAP_PEND=1 and irq high. A W1C in a non-wrap cycle drops irq one cycle later.
6. Write with byteenable=0x1 of 0xFFFF_FFFF to PERIOD (reset value 0xFF) -> PERIOD reads 0x00FF. Assert rst mid-period with irq high -> pwm_out=0, irq=0, and all registers return to their reset values.
